// File: rtl/sobel_window_reader.sv
// Sliding 3x3 window over a three-row column stream, producing saturated Sobel |Gx|+|Gy|
// tagged with the window centre. Define SOBEL_THRESHOLD_EN for a binarised, 3-cycle output.
module sobel_window_reader #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 10
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int THRESH = 128
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] grad_o,
  output logic [CNT_W-1:0]  x_o,
  output logic [CNT_W-1:0]  y_o,
  output logic              frame_done_o
);

  localparam int SW = DATA_W + 3;

  typedef enum logic {FILL, RUN} state_e;

  function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  // Index 0 is the oldest (leftmost) column, index 2 the newest.
  logic [2:0][DATA_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [CNT_W-1:0]       col_q, col_d, row_q, row_d;
  state_e                 state_q, state_d;
  logic                   col_end, row_end;

  logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [SW-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic [CNT_W-1:0]       s1_x_q, s1_x_d, s1_y_q, s1_y_d;

  logic [SW-1:0]          gx_abs, gy_abs, mag;
  logic                   s2_valid_q, s2_valid_d, s2_done_q, s2_done_d;
  logic [DATA_W-1:0]      s2_grad_q, s2_grad_d;
  logic [CNT_W-1:0]       s2_x_q, s2_x_d, s2_y_q, s2_y_d;

`ifdef SOBEL_THRESHOLD_EN
  logic                   s3_valid_q, s3_valid_d, s3_done_q, s3_done_d;
  logic [DATA_W-1:0]      s3_grad_q, s3_grad_d;
  logic [CNT_W-1:0]       s3_x_q, s3_x_d, s3_y_q, s3_y_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    col_end = (col_q == CNT_W'(IMG_W - 1));
    row_end = (row_q == CNT_W'(IMG_H - 3));

    if (valid_i) begin
      top_d = {data0_i, top_q[2], top_q[1]};
      mid_d = {data1_i, mid_q[2], mid_q[1]};
      bot_d = {data2_i, bot_q[2], bot_q[1]};
      col_d = col_end ? '0 : col_q + CNT_W'(1);
      if (col_end) row_d = row_end ? '0 : row_q + CNT_W'(1);
    end

    unique case (state_q)
      FILL: if (valid_i && col_q == CNT_W'(1)) state_d = RUN;
      RUN:  if (valid_i && col_end)            state_d = FILL;
      default: state_d = FILL;
    endcase

    // Stage 1 works on the post-shift window so a result lands two edges after its column.
    s1_valid_d = valid_i && (state_q == RUN);
    gx_d   = gx_q;
    gy_d   = gy_q;
    s1_x_d = s1_x_q;
    s1_y_d = s1_y_q;
    s1_last_d = s1_last_q;
    if (s1_valid_d) begin
      gx_d = (ext(top_d[2]) + (ext(mid_d[2]) <<< 1) + ext(bot_d[2]))
           - (ext(top_d[0]) + (ext(mid_d[0]) <<< 1) + ext(bot_d[0]));
      gy_d = (ext(bot_d[0]) + (ext(bot_d[1]) <<< 1) + ext(bot_d[2]))
           - (ext(top_d[0]) + (ext(top_d[1]) <<< 1) + ext(top_d[2]));
      s1_x_d    = col_q - CNT_W'(1);
      s1_y_d    = row_q + CNT_W'(1);
      s1_last_d = col_end && row_end;
    end

    gx_abs = gx_q[SW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    gy_abs = gy_q[SW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag    = gx_abs + gy_abs;
    s2_valid_d = s1_valid_q;
    s2_done_d  = s1_valid_q && s1_last_q;
    s2_grad_d  = s2_grad_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    if (s1_valid_q) begin
      s2_grad_d = (|mag[SW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
      s2_x_d    = s1_x_q;
      s2_y_d    = s1_y_q;
    end

`ifdef SOBEL_THRESHOLD_EN
    s3_valid_d = s2_valid_q;
    s3_done_d  = s2_done_q;
    s3_grad_d  = s3_grad_q;
    s3_x_d     = s3_x_q;
    s3_y_d     = s3_y_q;
    if (s2_valid_q) begin
      s3_grad_d = (int'(s2_grad_q) >= THRESH) ? '1 : '0;
      s3_x_d    = s2_x_q;
      s3_y_d    = s2_y_q;
    end
`endif
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      state_q    <= FILL;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_done_q  <= 1'b0;
      s2_grad_q  <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
`ifdef SOBEL_THRESHOLD_EN
      s3_valid_q <= 1'b0;
      s3_done_q  <= 1'b0;
      s3_grad_q  <= '0;
      s3_x_q     <= '0;
      s3_y_q     <= '0;
`endif
    end else begin
      top_q      <= top_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      col_q      <= col_d;
      row_q      <= row_d;
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s2_valid_q <= s2_valid_d;
      s2_done_q  <= s2_done_d;
      s2_grad_q  <= s2_grad_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
`ifdef SOBEL_THRESHOLD_EN
      s3_valid_q <= s3_valid_d;
      s3_done_q  <= s3_done_d;
      s3_grad_q  <= s3_grad_d;
      s3_x_q     <= s3_x_d;
      s3_y_q     <= s3_y_d;
`endif
    end
  end

`ifdef SOBEL_THRESHOLD_EN
  assign valid_o      = s3_valid_q;
  assign grad_o       = s3_grad_q;
  assign x_o          = s3_x_q;
  assign y_o          = s3_y_q;
  assign frame_done_o = s3_done_q;
`else
  assign valid_o      = s2_valid_q;
  assign grad_o       = s2_grad_q;
  assign x_o          = s2_x_q;
  assign y_o          = s2_y_q;
  assign frame_done_o = s2_done_q;
`endif

endmodule
